result_collector_tx: RTL
========================

Name: result_collector_tx

Overview:
- Return path of the matrix-vector engine.
- Gathers the per-row results produced by the four row processors over up to two passes: rows 0-3, then rows 4-7.
- Buffers the results in a result register file, then streams them byte-by-byte, row 0 first, to the UART transmitter over a valid/ready handshake.
- Drives the pass-select line that the row-distribution mux uses to pick the first or second half of the matrix.

Parameters:
- DATA_W, 8, width of one processor result and of one transmitted byte.
- N_PROC, 4, number of row processors (fixed at 4 for this block).
- MAX_ROWS, 8, maximum matrix dimension (2 x N_PROC).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that begins a collection run.
- size  input  4  matrix dimension for this run; legal range 1..8.
- P0_Res, P1_Res, P2_Res, P3_Res  input  DATA_W each  results from processors 0..3.
- res_valid  input  1  one-cycle pulse; all four P*_Res are valid for the current pass.
- pass_sel  output  1  1 = first pass (rows 0-3), 0 = second pass (rows 4-7).
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.
- err  output  1  one-cycle pulse when start arrives with an illegal size.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - Outputs: pass_sel=1, tx_valid=0, tx_data=0, busy=0, done=0, err=0.
  - Result buffer and counters cleared to 0.
  - Reset mid-run aborts the run immediately; the in-flight byte is dropped and no done is produced.
- States: IDLE, PASS1, PASS2, SEND, FIN.
- IDLE:
  - start with size in 1..8: latch size, go to PASS1, pass_sel=1.
  - start with size 0 or 9..15: pulse err next cycle, stay in IDLE.
- PASS1:
  - Wait for res_valid.
  - On res_valid, store P0..P3_Res into buf[0..3]. Only rows < size are written; the others keep 0.
  - If size<=4, go to SEND. Otherwise go to PASS2 and set pass_sel=0 in the same edge.
- PASS2:
  - On res_valid, store P0..P3_Res into buf[4..7], again only rows < size.
  - Go to SEND and set pass_sel=1.
- SEND:
  - tx_valid=1 and tx_data=buf[idx], with idx starting at 0.
  - tx_valid rises the cycle after the final capture edge.
  - While tx_ready=0, tx_data and tx_valid stay stable.
  - On a cycle with tx_valid and tx_ready both high, idx increments.
  - When the accepted byte has idx = size-1, drop tx_valid the next cycle and go to FIN.
  - Exactly size bytes are sent; no gaps are required but ready may stall indefinitely.
- FIN: done=1 for one cycle, then IDLE.
- Ignore rules:
  - start is ignored outside IDLE.
  - res_valid is ignored outside PASS1/PASS2.
  - res_valid and start in the same cycle while in IDLE: start is honoured, res_valid ignored.
- Widths:
  - idx is 3 bits, compared against size-1 (size is 4 bits, never 0 here).
  - No arithmetic on data; results pass through unmodified.
- busy equals (state != IDLE), registered.

Test Plan:
- Full run, size=8, tx_ready held 1:
  - Stimulus: start, then res_valid with P0..P3=0x11,0x22,0x33,0x44; pass_sel must read 0; then res_valid with 0x55,0x66,0x77,0x88.
  - Response: tx bytes 0x11..0x88 in order on 8 consecutive cycles, then one done pulse; pass_sel=1 at end.
- Single-pass run, size=3:
  - Stimulus: start, then res_valid with P0..P3=0xA0,0xA1,0xA2,0xA3.
  - Response: pass_sel never goes 0; exactly 0xA0,0xA1,0xA2 sent; 0xA3 not sent; done pulses.
- Backpressure, size=5:
  - Stimulus: tx_ready low for 4 cycles on byte 2.
  - Response: tx_data holds buf[2] stable with tx_valid=1; sequence completes with 5 bytes and no duplicates or drops.
- Illegal size:
  - Stimulus: start with size=0, and separately start with size=9.
  - Response: err pulses once each time, busy stays 0, no tx_valid.
- Spurious inputs:
  - Stimulus: res_valid pulsed in IDLE; start pulsed during SEND.
  - Response: both ignored, buffer unchanged, run completes normally.
- Reset mid-SEND, size=8:
  - Stimulus: rst_n low for 1 cycle after byte 3 is accepted.
  - Response: next cycle tx_valid=0, busy=0, pass_sel=1, no done; a new start with size=2 then works correctly.

Source files
------------

// File: rtl/result_collector_tx_if.sv
// Byte stream handshake from the result collector to the UART transmitter.
// Ports: tx_data/tx_valid driven by the master, tx_ready by the slave.
interface result_collector_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/result_collector_tx.sv
// Collects per-row results from four row processors over one or two passes,
// buffers them and streams them row 0 first to the UART transmitter.
// Ports: clk, rst_n (sync, active low), start/size (run request),
// P0..P3_Res/res_valid (processor results), pass_sel (row mux select),
// tx (byte stream master), busy, done, err (status pulses).
module result_collector_tx #(
    parameter int DATA_W   = 8,
    parameter int N_PROC   = 4,
    parameter int MAX_ROWS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        size,
    input  logic [DATA_W-1:0] P0_Res,
    input  logic [DATA_W-1:0] P1_Res,
    input  logic [DATA_W-1:0] P2_Res,
    input  logic [DATA_W-1:0] P3_Res,
    input  logic              res_valid,
    output logic              pass_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    result_collector_tx_if.master tx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_PASS2,
        S_SEND,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic [3:0]        size_q;
    logic [2:0]        idx;
    logic [DATA_W-1:0] res_buf [MAX_ROWS];
    logic [DATA_W-1:0] p_res   [N_PROC];

    logic start_ok;
    logic last;
    logic accept;

    assign p_res[0] = P0_Res;
    assign p_res[1] = P1_Res;
    assign p_res[2] = P2_Res;
    assign p_res[3] = P3_Res;

    assign start_ok = start && (size != 4'd0) && (size <= 4'(MAX_ROWS));
    // size_q is never 0 once a run is active, so size_q-1 cannot wrap.
    assign last     = ({1'b0, idx} == (size_q - 4'd1));
    assign accept   = (state == S_SEND) && tx.tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) state_n = S_PASS1;
            end
            S_PASS1: begin
                if (res_valid) begin
                    if (size_q <= 4'(N_PROC)) state_n = S_SEND;
                    else                      state_n = S_PASS2;
                end
            end
            S_PASS2: begin
                if (res_valid) state_n = S_SEND;
            end
            S_SEND: begin
                if (accept && last) state_n = S_FIN;
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx.tx_valid = (state == S_SEND);
        tx.tx_data  = '0;
        if (state == S_SEND) tx.tx_data = res_buf[idx];
    end

    assign done = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            size_q   <= '0;
            idx      <= '0;
            pass_sel <= 1'b1;
            busy     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < MAX_ROWS; i++) res_buf[i] <= '0;
        end else begin
            busy <= (state_n != S_IDLE);
            err  <= (state == S_IDLE) && start && !start_ok;

            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        size_q   <= size;
                        idx      <= '0;
                        pass_sel <= 1'b1;
                        // Rows at or beyond size stay zero for this run.
                        for (int i = 0; i < MAX_ROWS; i++) res_buf[i] <= '0;
                    end
                end
                S_PASS1: begin
                    if (res_valid) begin
                        for (int i = 0; i < N_PROC; i++) begin
                            if (4'(i) < size_q) res_buf[i] <= p_res[i];
                        end
                        if (size_q > 4'(N_PROC)) pass_sel <= 1'b0;
                    end
                end
                S_PASS2: begin
                    if (res_valid) begin
                        for (int i = 0; i < N_PROC; i++) begin
                            if (4'(i + N_PROC) < size_q)
                                res_buf[i + N_PROC] <= p_res[i];
                        end
                        pass_sel <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        if (last) idx <= '0;
                        else      idx <= idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
